// File: rtl/branch_resolve_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : branch_resolve_unit_if
//  Brief    : EX-stage resolve / ID-stage prediction bundle for the BRU.
//  Revision : 1.0 - initial release
// ============================================================================
interface branch_resolve_unit_if;
    logic        Branch_i;
    logic        Predict_i;
    logic        Taken_i;
    logic [31:0] PC_i;
    logic [31:0] branch_pc_i;
    logic        ID_Branch_i;
    logic        Predict_o;
    logic        Flush_o;
    logic        Redirect_o;
    logic [31:0] redirect_pc_o;
    logic [15:0] branch_cnt_o;
    logic [15:0] mispredict_cnt_o;

    // Pipeline side drives resolve info and consumes prediction/redirect.
    modport master (
        output Branch_i, Predict_i, Taken_i, PC_i, branch_pc_i, ID_Branch_i,
        input  Predict_o, Flush_o, Redirect_o, redirect_pc_o,
               branch_cnt_o, mispredict_cnt_o
    );

    modport slave (
        input  Branch_i, Predict_i, Taken_i, PC_i, branch_pc_i, ID_Branch_i,
        output Predict_o, Flush_o, Redirect_o, redirect_pc_o,
               branch_cnt_o, mispredict_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
//  Module   : branch_resolve_unit
//  Brief    : Global 2-bit branch predictor with EX-stage resolve, flush and
//             redirect. Optional statistics counters under BRU_STATS_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module branch_resolve_unit (
    input  wire logic             clk_i,
    input  wire logic             rst_i,
    branch_resolve_unit_if.slave  bus
);
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } state_t;

    state_t state_q, state_d;
    logic   w_resolve;
    logic   w_mispredict;

    assign w_resolve    = bus.Branch_i;
    assign w_mispredict = bus.Predict_i ^ bus.Taken_i;

    always_comb begin
        state_d = state_q;
        if (w_resolve) begin
            if (bus.Taken_i) begin
                case (state_q)
                    SNT:     state_d = WNT;
                    WNT:     state_d = WT;
                    default: state_d = ST;
                endcase
            end else begin
                case (state_q)
                    ST:      state_d = WT;
                    WT:      state_d = WNT;
                    default: state_d = SNT;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST;
        else       state_q <= state_d;
    end

    // Prediction uses the registered state only; same-cycle updates land next edge.
    assign bus.Predict_o     = state_q[1] & bus.ID_Branch_i;
    assign bus.Flush_o       = w_resolve & w_mispredict;
    assign bus.Redirect_o    = w_resolve & w_mispredict;
    assign bus.redirect_pc_o = (w_resolve & w_mispredict)
                             ? (bus.Taken_i ? bus.branch_pc_i : bus.PC_i + 32'd4)
                             : 32'd0;

`ifdef BRU_STATS_EN
    logic [15:0] branch_cnt_q;
    logic [15:0] mispredict_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            branch_cnt_q     <= 16'd0;
            mispredict_cnt_q <= 16'd0;
        end else if (w_resolve) begin
            if (branch_cnt_q != 16'hFFFF)
                branch_cnt_q <= branch_cnt_q + 16'd1;
            if (w_mispredict && (mispredict_cnt_q != 16'hFFFF))
                mispredict_cnt_q <= mispredict_cnt_q + 16'd1;
        end
    end

    assign bus.branch_cnt_o     = branch_cnt_q;
    assign bus.mispredict_cnt_o = mispredict_cnt_q;
`else
    assign bus.branch_cnt_o     = 16'd0;
    assign bus.mispredict_cnt_o = 16'd0;
`endif

endmodule
`default_nettype wire
